maxpool_with_mem: RTL and testbench
===================================

Name: maxpool_with_mem

Overview:
- 2x2, stride-2 max-pooling stage that sits directly downstream of relu_with_mem in the CNN datapath.
- On start, it reads a HEIGHT x WIDTH signed feature map from shared memory at input_addr, row-major, one element per bus word.
- It writes the (HEIGHT/2) x (WIDTH/2) pooled map to output_addr, row-major.
- It shares the tri-state address/data bus with the other memory masters; an upstream ReLU output region is its usual input.

Parameters:
- DATA_WIDTH, 8: signed element width, held in the low bits of each bus word.
- ADDR_WIDTH, 8: memory address width.
- DATABUS_WIDTH, 32: memory word width; must be >= DATA_WIDTH.
- HEIGHT, 4: input rows; must be even and >= 2.
- WIDTH, 4: input columns; must be even and >= 2.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  begin operation; sampled only in IDLE or DONE.
- done  output  1  operation complete; level signal.
- input_addr  input  ADDR_WIDTH  base address of input map; latched on start.
- output_addr  input  ADDR_WIDTH  base address of output map; latched on start.
- mem_w  output  1  memory write enable.
- mem_sel  output  1  memory select.
- address_bus  inout  ADDR_WIDTH  driven only while mem_sel=1, else Z.
- data_bus  inout  DATABUS_WIDTH  driven only during a write cycle, else Z.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, done=0, mem_sel=0, mem_w=0.
  - address_bus=Z, data_bus=Z; all counters and the running max are cleared.
  - Reset mid-operation aborts immediately; memory words already written remain.
- Memory contract:
  - Write: takes effect at the posedge where sel=1 and w_en=1.
  - Read: address is driven from a posedge (cycle t); data_bus is captured at the posedge ending cycle t+1.
- States:
  - IDLE: bus released. start=1 -> latch addresses, clear the output index and window index k, go to RD_ADDR.
  - RD_ADDR: mem_sel=1, mem_w=0. Drive the address of window element k (k=0..3 for TL, TR, BL, BR): in_base + (2*orow + (k>>1))*WIDTH + 2*ocol + (k&1). Next state RD_CAP.
  - RD_CAP: mem_sel=1, mem_w=0, address held. Capture data_bus[DATA_WIDTH-1:0] as signed.
    - k=0 -> max=value; otherwise max=(value>max)?value:max (signed compare).
    - k<3 -> k++, go to RD_ADDR; k=3 -> go to WR.
  - WR: mem_sel=1, mem_w=1. address_bus = out_base + orow*(WIDTH/2) + ocol. data_bus = max sign-extended to DATABUS_WIDTH.
    - Advance ocol, then orow. After the last output go to DONE, else RD_ADDR with k=0.
  - DONE: done=1, bus released. start=1 -> clear done and restart exactly as from IDLE with fresh latched addresses.
- Timing:
  - 9 cycles per output; P = (HEIGHT/2)*(WIDTH/2) outputs.
  - done rises 9*P+1 posedges after the start-sampling edge.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is legal and silent.
- Upper input bits above DATA_WIDTH are ignored.
- start while busy (RD_ADDR/RD_CAP/WR) is ignored; input_addr/output_addr changes while busy are ignored.
- Overlapping input and output regions are not supported; results are undefined.

Optional Feature:
- Macro MAXPOOL_FUSED_RELU_EN.
- Defined: at k=0 the running max is initialised to max(value, 0), so each output = max(0, window max). Fuses the ReLU stage and saves one memory pass.
- Undefined: plain signed max; negative results pass through.
- Timing is identical either way.

Test Plan:
- 4x4 map, rows [-3,-1,0,5] [127,-128,2,2] [-5,-6,-7,-8] [-9,-10,-11,-128], input_addr=0, output_addr=100, start pulse -> mem[100..103] = 127, 5, -5, -7 (sign-extended). With MAXPOOL_FUSED_RELU_EN: 127, 5, 0, 0.
- 2x2 map, all -128 -> mem[out] = -128 (0xFFFFFF80). done rises exactly 10 posedges after the start edge.
- Bus release:
  - In IDLE and DONE: address_bus and data_bus are Z and mem_sel=0.
  - data_bus is driven only in WR cycles (mem_w=1); a TB read of output after done succeeds.
- Wrap-around: 4x4 map, input_addr=250 (data at 250..255, 0..9), output_addr=20 -> correct pooled values at 20..23.
- Start while busy: second start pulse 5 cycles after the first is ignored; done timing is unchanged. A start in DONE reruns with new output_addr=40 and clears done for the run.
- Reset mid-operation: rst=0 during the 2nd output's reads -> same cycle mem_sel=0, buses Z, done=0. After release, a new start completes correctly.

Source files
------------

// File: rtl/maxpool_with_mem.sv
// maxpool_with_mem: 2x2 stride-2 signed max-pool over a shared tri-state memory bus.
// Define MAXPOOL_FUSED_RELU_EN to clamp each pooled result at zero (fused ReLU).
module maxpool_with_mem #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATABUS_WIDTH = 32,
    parameter int HEIGHT        = 4,
    parameter int WIDTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     done,
    input  logic [ADDR_WIDTH-1:0]    input_addr,
    input  logic [ADDR_WIDTH-1:0]    output_addr,
    output logic                     mem_w,
    output logic                     mem_sel,
    inout  wire  [ADDR_WIDTH-1:0]    address_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAP, WR, DONE} state_t;
    state_t state, nxt;
    logic [ADDR_WIDTH-1:0] in_base, out_base, orow, ocol, rd_addr, wr_addr;
    logic [1:0] k;
    logic signed [DATA_WIDTH-1:0] mx, val, init;
    logic go, last, col_end;
    assign go      = start && (state == IDLE || state == DONE);
    assign col_end = ocol == ADDR_WIDTH'(WIDTH/2 - 1);
    assign last    = col_end && orow == ADDR_WIDTH'(HEIGHT/2 - 1);
    assign val     = data_bus[DATA_WIDTH-1:0];
`ifdef MAXPOOL_FUSED_RELU_EN
    assign init = val[DATA_WIDTH-1] ? '0 : val;
`else
    assign init = val;
`endif
    assign rd_addr = in_base + ((orow << 1) + ADDR_WIDTH'(k[1])) * ADDR_WIDTH'(WIDTH)
                   + (ocol << 1) + ADDR_WIDTH'(k[0]);
    assign wr_addr = out_base + orow * ADDR_WIDTH'(WIDTH/2) + ocol;
    assign address_bus = mem_sel ? (mem_w ? wr_addr : rd_addr) : 'z;
    assign data_bus    = mem_w ? DATABUS_WIDTH'(mx) : 'z;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= nxt;
    always_comb begin
        nxt     = state;
        mem_sel = state == RD_ADDR || state == RD_CAP || state == WR;
        mem_w   = state == WR;
        case (state)
            IDLE, DONE: nxt = start ? RD_ADDR : state;
            RD_ADDR:    nxt = RD_CAP;
            RD_CAP:     nxt = k == 2'd3 ? WR : RD_ADDR;
            WR:         nxt = last ? DONE : RD_ADDR;
            default:    nxt = IDLE;
        endcase
    end
    // done lags entry into DONE by one edge so the final write has landed
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            done     <= 1'b0;
            in_base  <= '0;
            out_base <= '0;
            orow     <= '0;
            ocol     <= '0;
            k        <= '0;
            mx       <= '0;
        end else begin
            done <= state == DONE && !start;
            if (go) begin
                in_base  <= input_addr;
                out_base <= output_addr;
                orow     <= '0;
                ocol     <= '0;
                k        <= '0;
            end else if (state == RD_CAP) begin
                mx <= k == 2'd0 ? init : (val > mx ? val : mx);
                k  <= k + 2'd1;
            end else if (state == WR) begin
                ocol <= col_end ? '0 : ocol + 1'b1;
                orow <= col_end ? orow + 1'b1 : orow;
            end
        end
endmodule

// File: tb/tb_maxpool_with_mem.sv
// tb_maxpool_with_mem: randomized self-checking bench for a 4x4 maxpool_with_mem against a window-max model.
module tb_maxpool_with_mem;
    localparam logic [7:0]  ADDR_IDLE = 8'hA5;
    localparam logic [31:0] DATA_IDLE = 32'h5A5A_C3C3;
    localparam logic [31:0] SENTINEL  = 32'hDEAD_BEEF;
    localparam int          RUN_LEN   = 9 * 4 + 1;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [7:0] input_addr = '0, output_addr = '0;
    logic done, mem_w, mem_sel;
    wire [7:0]  address_bus;
    wire [31:0] data_bus;

    logic [31:0] mem [256];
    logic        load_en = 1'b0;
    logic [7:0]  load_a = '0;
    logic [31:0] load_d = '0;
    int img [16];
    int passed = 0, total = 0;

    maxpool_with_mem dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .input_addr(input_addr), .output_addr(output_addr),
        .mem_w(mem_w), .mem_sel(mem_sel),
        .address_bus(address_bus), .data_bus(data_bus)
    );

    always #5 clk = ~clk;

    // Memory model plus weak idle patterns that reveal any stray DUT drive
    assign address_bus = mem_sel ? 'z : ADDR_IDLE;
    assign data_bus    = !mem_sel ? DATA_IDLE : (mem_w ? 'z : mem[address_bus]);
    always @(posedge clk)
        if (mem_sel && mem_w) mem[address_bus] <= data_bus;
        else if (load_en)     mem[load_a] <= load_d;

    function automatic int expv(input int r, input int c);
        int m = img[(2*r)*4 + 2*c];
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (img[(2*r+dr)*4 + 2*c+dc] > m) m = img[(2*r+dr)*4 + 2*c+dc];
`ifdef MAXPOOL_FUSED_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    task automatic mem_load(input logic [7:0] a, input logic [31:0] d);
        load_a = a; load_d = d; load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic load_map(input logic [7:0] base);
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = $urandom();
            w[7:0] = img[i][7:0];
            mem_load(base + 8'(i), w);
        end
    endtask

    task automatic random_map();
        for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic run(input logic [7:0] ia, input logic [7:0] oa, input bit busy_start, output int n);
        input_addr = ia; output_addr = oa; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (busy_start && n == 5) begin
                start = 1'b1; input_addr = ia + 8'd3; output_addr = oa + 8'd50;
            end else start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (mem_sel !== 1'b0) $display("FAIL reset_sel: got %b expected 0", mem_sel); else passed++;
        total++; if (mem_w !== 1'b0) $display("FAIL reset_w: got %b expected 0", mem_w); else passed++;
        total++; if (address_bus !== ADDR_IDLE) $display("FAIL reset_addr_bus: got %h expected %h", address_bus, ADDR_IDLE); else passed++;
        total++; if (data_bus !== DATA_IDLE) $display("FAIL reset_data_bus: got %h expected %h", data_bus, DATA_IDLE); else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (address_bus !== ADDR_IDLE || mem_sel !== 1'b0) $display("FAIL idle_bus: got sel=%b addr=%h expected sel=0 addr=%h", mem_sel, address_bus, ADDR_IDLE); else passed++;
    endtask

    task automatic test_fixed_map();
        int n;
        logic [31:0] e [4];
        img = '{-3, -1, 0, 5, 127, -128, 2, 2, -5, -6, -7, -8, -9, -10, -11, -128};
`ifdef MAXPOOL_FUSED_RELU_EN
        e = '{32'd127, 32'd5, 32'd0, 32'd0};
`else
        e = '{32'd127, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFF9};
`endif
        load_map(8'd0);
        run(8'd0, 8'd100, 1'b0, n);
        total++; if (n !== RUN_LEN) $display("FAIL fixed_done_latency: got %0d expected %0d", n, RUN_LEN); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[8'd100 + 8'(i)] !== e[i]) $display("FAIL fixed_out[%0d]: got %h expected %h", i, mem[8'd100 + 8'(i)], e[i]); else passed++;
        end
        total++; if (mem_sel !== 1'b0 || address_bus !== ADDR_IDLE) $display("FAIL done_addr_bus: got sel=%b addr=%h expected sel=0 addr=%h", mem_sel, address_bus, ADDR_IDLE); else passed++;
        total++; if (data_bus !== DATA_IDLE) $display("FAIL done_data_bus: got %h expected %h", data_bus, DATA_IDLE); else passed++;
    endtask

    task automatic test_all_min();
        int n;
        for (int i = 0; i < 16; i++) img[i] = -128;
        load_map(8'd30);
        run(8'd30, 8'd60, 1'b0, n);
        total++; if (n !== RUN_LEN) $display("FAIL min_done_latency: got %0d expected %0d", n, RUN_LEN); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[8'd60 + 8'(i)] !== 32'(expv(i/2, i%2))) $display("FAIL min_out[%0d]: got %h expected %h", i, mem[8'd60 + 8'(i)], 32'(expv(i/2, i%2))); else passed++;
        end
    endtask

    task automatic test_random();
        int n;
        logic [7:0] ia, oa;
        for (int t = 0; t < 5; t++) begin
            random_map();
            ia = t == 0 ? 8'd250 : 8'($urandom_range(0, 255));
            oa = t == 0 ? 8'd20 : ia + 8'd16 + 8'($urandom_range(0, 236));
            load_map(ia);
            run(ia, oa, 1'b0, n);
            total++; if (n !== RUN_LEN) $display("FAIL rand%0d_latency: got %0d expected %0d", t, n, RUN_LEN); else passed++;
            for (int i = 0; i < 4; i++) begin
                total++;
                if (mem[oa + 8'(i)] !== 32'(expv(i/2, i%2))) $display("FAIL rand%0d_out[%0d]: got %h expected %h", t, i, mem[oa + 8'(i)], 32'(expv(i/2, i%2))); else passed++;
            end
        end
    endtask

    task automatic test_start_busy();
        int n;
        random_map();
        load_map(8'd0);
        for (int i = 0; i < 4; i++) mem_load(8'd40 + 8'(i), SENTINEL);
        run(8'd0, 8'd120, 1'b1, n);
        total++; if (n !== RUN_LEN) $display("FAIL busy_latency: got %0d expected %0d", n, RUN_LEN); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[8'd120 + 8'(i)] !== 32'(expv(i/2, i%2))) $display("FAIL busy_out[%0d]: got %h expected %h", i, mem[8'd120 + 8'(i)], 32'(expv(i/2, i%2))); else passed++;
        end
        run(8'd0, 8'd40, 1'b0, n);
        total++; if (n !== RUN_LEN) $display("FAIL rerun_latency: got %0d expected %0d", n, RUN_LEN); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[8'd40 + 8'(i)] !== 32'(expv(i/2, i%2))) $display("FAIL rerun_out[%0d]: got %h expected %h", i, mem[8'd40 + 8'(i)], 32'(expv(i/2, i%2))); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        random_map();
        load_map(8'd0);
        for (int i = 0; i < 4; i++) mem_load(8'd200 + 8'(i), SENTINEL);
        input_addr = 8'd0; output_addr = 8'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (mem_sel !== 1'b0 || mem_w !== 1'b0) $display("FAIL abort_ctrl: got sel=%b w=%b expected 0 0", mem_sel, mem_w); else passed++;
        total++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else passed++;
        total++; if (address_bus !== ADDR_IDLE) $display("FAIL abort_addr_bus: got %h expected %h", address_bus, ADDR_IDLE); else passed++;
        total++; if (mem[200] !== 32'(expv(0, 0))) $display("FAIL abort_kept: got %h expected %h", mem[200], 32'(expv(0, 0))); else passed++;
        total++; if (mem[201] !== SENTINEL) $display("FAIL abort_unwritten: got %h expected %h", mem[201], SENTINEL); else passed++;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        run(8'd0, 8'd200, 1'b0, n);
        total++; if (n !== RUN_LEN) $display("FAIL post_reset_latency: got %0d expected %0d", n, RUN_LEN); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[8'd200 + 8'(i)] !== 32'(expv(i/2, i%2))) $display("FAIL post_reset_out[%0d]: got %h expected %h", i, mem[8'd200 + 8'(i)], 32'(expv(i/2, i%2))); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fixed_map();
        test_all_min();
        test_random();
        test_start_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
